// File: rtl/alu_pipe_unit_if.sv
// alu_pipe_unit_if: operand/result handshake bundle between issue, ALU pipe and writeback
interface alu_pipe_unit_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int TAG_WIDTH     = 5
);
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic [TAG_WIDTH-1:0]     in_tag;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    Rd;
    logic [TAG_WIDTH-1:0]     out_tag;
    logic                     out_illegal;
    logic                     busy;
    modport master (
        output flush, in_valid, SrcA, SrcB, Operation, in_tag, out_ready,
        input  in_ready, out_valid, Rd, out_tag, out_illegal, busy
    );
    modport slave (
        input  flush, in_valid, SrcA, SrcB, Operation, in_tag, out_ready,
        output in_ready, out_valid, Rd, out_tag, out_illegal, busy
    );
endinterface

// File: rtl/alu_pipe_unit.sv
// alu_pipe_unit: pipelined ALU with valid/ready flow control, bubble collapse and flush
module alu_pipe_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int TAG_WIDTH     = 5,
    parameter int STAGES        = 2
) (
    input logic clk,
    input logic reset,
    alu_pipe_unit_if.slave bus
);
    localparam int SW = $clog2(DATA_WIDTH);
    logic [DATA_WIDTH-1:0] res;
    logic                  ill;
    logic [SW-1:0]         sh;
    logic [STAGES-1:0]     v, acc, sv, il, si;
    logic [DATA_WIDTH-1:0] d [STAGES];
    logic [DATA_WIDTH-1:0] sd [STAGES];
    logic [TAG_WIDTH-1:0]  t [STAGES];
    logic [TAG_WIDTH-1:0]  st [STAGES];
    logic                  full;
    assign sh = bus.SrcB[SW-1:0];
    always_comb begin
        res = '0;
        ill = 1'b0;
        case (bus.Operation)
            4'b0000: res = bus.SrcA & bus.SrcB;
            4'b0001: res = bus.SrcA | bus.SrcB;
            4'b0010: res = bus.SrcA + bus.SrcB;
            4'b0110: res = bus.SrcA - bus.SrcB;
            4'b1001: res = bus.SrcA ^ bus.SrcB;
            4'b0011: res = bus.SrcA << sh;
            4'b0100: res = bus.SrcA >> sh;
            4'b0101: res = $signed(bus.SrcA) >>> sh;
            4'b1000: res = DATA_WIDTH'($signed(bus.SrcA) < $signed(bus.SrcB));
            default: ill = 1'b1;
        endcase
    end
    // a stage can load when it or any stage downstream of it has a hole, or the output drains
    always_comb begin
        full = 1'b1;
        acc  = '0;
        sv   = '0;
        si   = '0;
        sd   = '{default: '0};
        st   = '{default: '0};
        for (int k = STAGES - 1; k >= 0; k--) begin
            full   = full & v[k];
            acc[k] = bus.out_ready | ~full;
        end
        sv[0] = bus.in_valid;
        sd[0] = res;
        st[0] = bus.in_tag;
        si[0] = ill;
        for (int k = 1; k < STAGES; k++) begin
            sv[k] = v[k-1];
            sd[k] = d[k-1];
            st[k] = t[k-1];
            si[k] = il[k-1];
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            v  <= '0;
            il <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d[k] <= '0;
                t[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (acc[k] && sv[k]) begin
                    d[k]  <= sd[k];
                    t[k]  <= st[k];
                    il[k] <= si[k];
                end
            end
            v <= bus.flush ? '0 : (v & ~acc) | (sv & acc);
        end
    end
    assign bus.in_ready    = acc[0];
    assign bus.out_valid   = v[STAGES-1];
    assign bus.Rd          = d[STAGES-1];
    assign bus.out_tag     = t[STAGES-1];
    assign bus.out_illegal = il[STAGES-1];
    assign bus.busy        = |v;
endmodule

// File: tb/tb_alu_pipe_unit.sv
// tb_alu_pipe_unit: directed and random checks of alu_pipe_unit against a queue-based reference
module tb_alu_pipe_unit;
    localparam int DW = 32;
    localparam int OL = 4;
    localparam int TW = 5;
    localparam int ST = 2;
    typedef struct packed {
        logic          ill;
        logic [TW-1:0] tag;
        logic [DW-1:0] rd;
    } ent_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    int cyc_n = 0;
    ent_t q[$];
    ent_t outs[$];
    int stamps[$];
    logic [DW-1:0] exp_s [4] = '{32'h0, 32'hFFFF_FFFF, 32'hF800_0000, 32'h1};
    always #5 clk = ~clk;
    alu_pipe_unit_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL), .TAG_WIDTH(TW)) bus();
    alu_pipe_unit #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL), .TAG_WIDTH(TW), .STAGES(ST)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );
    function automatic ent_t model(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic [TW-1:0] tag);
        ent_t e;
        e.tag = tag;
        e.ill = 1'b0;
        case (op)
            4'h0: e.rd = a & b;
            4'h1: e.rd = a | b;
            4'h2: e.rd = a + b;
            4'h6: e.rd = a - b;
            4'h9: e.rd = a ^ b;
            4'h3: e.rd = a << b[4:0];
            4'h4: e.rd = a >> b[4:0];
            4'h5: e.rd = $signed(a) >>> b[4:0];
            4'h8: e.rd = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: begin
                e.rd  = '0;
                e.ill = 1'b1;
            end
        endcase
        return e;
    endfunction
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic put(input logic v, input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [TW-1:0] tg);
        bus.in_valid  = v;
        bus.Operation = op;
        bus.SrcA      = a;
        bus.SrcB      = b;
        bus.in_tag    = tg;
    endtask
    task automatic cyc(output logic took);
        #1;
        took = bus.in_valid && bus.in_ready && !bus.flush && !reset;
        if (!reset) begin
            chk("in_ready", bus.in_ready, (q.size() < ST) || bus.out_ready);
            chk("busy", bus.busy, q.size() != 0);
            if (bus.out_valid && q.size() > 0)
                chk("result", {bus.out_illegal, bus.out_tag, bus.Rd}, q[0]);
            if (bus.out_valid && bus.out_ready) begin
                outs.push_back({bus.out_illegal, bus.out_tag, bus.Rd});
                stamps.push_back(cyc_n);
                if (q.size() > 0) void'(q.pop_front());
            end
        end
        if (took) q.push_back(model(bus.Operation, bus.SrcA, bus.SrcB, bus.in_tag));
        if (bus.flush || reset) q.delete();
        cyc_n++;
        @(posedge clk);
        @(negedge clk);
    endtask
    initial begin
        logic t;
        logic [DW-1:0] hold;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        put(1'b0, 4'h0, '0, '0, '0);
        @(negedge clk);
        cyc(t);
        cyc(t);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_rd", bus.Rd, 0);
        chk("rst_tag", bus.out_tag, 0);
        chk("rst_ill", bus.out_illegal, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        // XOR latency
        put(1'b1, 4'h9, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd5);
        cyc(t);
        chk("xor_acc", t, 1);
        put(1'b0, 4'h0, '0, '0, '0);
        chk("xor_lat0", bus.out_valid, 0);
        cyc(t);
        chk("xor_lat1", bus.out_valid, 1);
        chk("xor_rd", bus.Rd, 32'hFF00_FF00);
        chk("xor_tag", bus.out_tag, 5);
        chk("xor_ill", bus.out_illegal, 0);
        cyc(t);
        chk("xor_lat2", bus.out_valid, 0);
        // back-to-back stream
        outs.delete();
        stamps.delete();
        put(1'b1, 4'h2, 32'hFFFF_FFFF, 32'h1, 5'd1);
        cyc(t);
        chk("b2b_acc0", t, 1);
        put(1'b1, 4'h6, 32'h0, 32'h1, 5'd2);
        cyc(t);
        chk("b2b_acc1", t, 1);
        put(1'b1, 4'h5, 32'h8000_0000, 32'h4, 5'd3);
        cyc(t);
        chk("b2b_acc2", t, 1);
        put(1'b1, 4'h8, 32'hFFFF_FFFF, 32'h1, 5'd4);
        cyc(t);
        chk("b2b_acc3", t, 1);
        put(1'b0, 4'h0, '0, '0, '0);
        for (int i = 0; i < 4; i++) cyc(t);
        chk("b2b_count", outs.size(), 4);
        for (int i = 0; i < 4 && i < outs.size(); i++) chk("b2b_rd", outs[i].rd, exp_s[i]);
        if (stamps.size() == 4) chk("b2b_rate", stamps[3] - stamps[0], 3);
        // back-pressure
        outs.delete();
        bus.out_ready = 1'b0;
        put(1'b1, 4'h2, 32'd10, 32'd1, 5'd1);
        cyc(t);
        chk("bp_acc0", t, 1);
        put(1'b1, 4'h2, 32'd20, 32'd2, 5'd2);
        cyc(t);
        chk("bp_acc1", t, 1);
        put(1'b1, 4'h2, 32'd30, 32'd3, 5'd3);
        hold = bus.Rd;
        cyc(t);
        chk("bp_block0", t, 0);
        cyc(t);
        chk("bp_block1", t, 0);
        chk("bp_stable", bus.Rd, hold);
        bus.out_ready = 1'b1;
        cyc(t);
        chk("bp_acc2", t, 1);
        put(1'b0, 4'h0, '0, '0, '0);
        for (int i = 0; i < 4; i++) cyc(t);
        chk("bp_count", outs.size(), 3);
        for (int i = 0; i < 3 && i < outs.size(); i++) chk("bp_order", outs[i].tag, i + 1);
        // flush with two in flight and a same-cycle input
        put(1'b1, 4'h0, 32'hFF, 32'h0F, 5'd11);
        cyc(t);
        put(1'b1, 4'h1, 32'hF0, 32'h0F, 5'd12);
        cyc(t);
        put(1'b1, 4'h2, 32'd1, 32'd2, 5'd13);
        bus.flush = 1'b1;
        cyc(t);
        bus.flush = 1'b0;
        put(1'b0, 4'h0, '0, '0, '0);
        outs.delete();
        for (int i = 0; i < 3; i++) begin
            chk("flush_ov", bus.out_valid, 0);
            chk("flush_busy", bus.busy, 0);
            cyc(t);
        end
        put(1'b1, 4'h9, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd7);
        cyc(t);
        put(1'b0, 4'h0, '0, '0, '0);
        for (int i = 0; i < 3; i++) cyc(t);
        chk("post_flush_n", outs.size(), 1);
        if (outs.size() > 0) chk("post_flush_rd", {outs[0].tag, outs[0].rd}, {5'd7, 32'hFF00_FF00});
        // illegal opcode
        outs.delete();
        put(1'b1, 4'hF, 32'd7, 32'd3, 5'd9);
        cyc(t);
        put(1'b1, 4'h9, 32'd1, 32'd2, 5'd10);
        cyc(t);
        put(1'b0, 4'h0, '0, '0, '0);
        for (int i = 0; i < 3; i++) cyc(t);
        chk("ill_n", outs.size(), 2);
        if (outs.size() == 2) begin
            chk("ill_rd", outs[0].rd, 0);
            chk("ill_flag", outs[0].ill, 1);
            chk("ill_next", outs[1].ill, 0);
        end
        // reset mid-flight
        bus.out_ready = 1'b0;
        put(1'b1, 4'h2, 32'd5, 32'd6, 5'd1);
        cyc(t);
        put(1'b1, 4'h2, 32'd7, 32'd8, 5'd2);
        cyc(t);
        put(1'b0, 4'h0, '0, '0, '0);
        reset = 1'b1;
        cyc(t);
        reset = 1'b0;
        #1;
        chk("mrst_ov", bus.out_valid, 0);
        chk("mrst_rd", bus.Rd, 0);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_in_ready", bus.in_ready, 1);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            put($urandom_range(3) != 0, 4'($urandom), $urandom, ($urandom_range(1) != 0) ? $urandom : $urandom_range(40),
                5'($urandom));
            bus.out_ready = $urandom_range(2) != 0;
            bus.flush = $urandom_range(30) == 0;
            cyc(t);
        end
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        put(1'b0, 4'h0, '0, '0, '0);
        for (int i = 0; i < 6; i++) cyc(t);
        chk("drain_q", q.size(), 0);
        chk("drain_busy", bus.busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_pipe_unit.md
Name: alu_pipe_unit

Overview:
- Pipelined, parametrised successor to the single-operation combinational ALU wrappers (the XOR wrapper and similar).
- Accepts one operation per cycle over a valid/ready handshake, computes the result in the first stage, and carries it through STAGES registered stages toward the writeback path.
- Each result carries a destination tag.
- Supports back-pressure, bubble collapse and a pipeline flush for branch mispredicts.

Parameters:
- DATA_WIDTH, 32, width of operands and result.
- OPCODE_LENGTH, 4, width of Operation code.
- TAG_WIDTH, 5, width of destination tag (rd index).
- STAGES, 2, number of register stages from input to output; legal range 1..8.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  kills every in-flight and same-cycle-input operation.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  unit can accept an operation this cycle.
- SrcA  input  DATA_WIDTH  operand rs1.
- SrcB  input  DATA_WIDTH  operand rs2 or immediate.
- Operation  input  OPCODE_LENGTH  operation select.
- in_tag  input  TAG_WIDTH  destination tag.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- Rd  output  DATA_WIDTH  result.
- out_tag  output  TAG_WIDTH  tag of the result.
- out_illegal  output  1  result came from an unsupported Operation code.
- busy  output  1  at least one stage holds a valid entry.

Behaviour:
- Operation encoding:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 1001 XOR.
  - 0011 SLL, 0100 SRL, 0101 SRA; shift amount is SrcB[$clog2(DATA_WIDTH)-1:0].
  - 1000 SLT (signed, result 0 or 1).
  - All other codes: result 0, illegal flag 1.
- ADD/SUB wrap modulo 2^DATA_WIDTH; no carry or overflow output.
- Stage structure and transfer:
  - Stage 0 captures the computed result, tag and illegal flag.
  - Stages 1..STAGES-1 only carry the entry.
  - Outputs are driven directly from stage STAGES-1 registers (no combinational path from SrcA/SrcB to Rd).
  - Latency: an operation accepted at edge N is presented at out_valid at edge N+STAGES-1, i.e. visible the cycle after N+STAGES-1 for STAGES=1. Put simply, a result appears STAGES cycles after the accept cycle if never stalled.
  - Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Advance rule, evaluated per stage from the output backward:
  - Last stage advances when it is empty or out_ready=1.
  - Stage k advances when stage k+1 is empty or stage k+1 advances (bubbles collapse).
  - An entry that cannot advance holds its value.
- in_ready = !stage0_valid || stage0_advances. in_ready is combinational from out_ready and the valid bits, never from in_valid.
- While out_valid=1 and out_ready=0, Rd, out_tag and out_illegal stay stable.
- Flush:
  - When flush=1 at an edge, every stage valid bit clears and any same-cycle input transfer is discarded.
  - out_valid=0 from the next cycle.
  - Data registers need not clear.
  - in_ready behaves normally during the flush cycle.
  - The first operation accepted after flush deasserts runs with normal latency.
- Reset:
  - At an edge with reset=1, all valid bits clear and all data, tag and illegal registers become 0.
  - Outputs after reset: out_valid=0, Rd=0, out_tag=0, out_illegal=0, busy=0, in_ready=1.
  - Reset mid-operation drops all entries.
  - Reset has priority over flush and input.
- busy = OR of all stage valid bits.
- Throughput: one operation per cycle while out_ready=1. The pipeline holds at most STAGES entries, no more.

Test Plan:
- Reset, then in_valid with SrcA=32'hF0F0_F0F0, SrcB=32'h0FF0_0FF0, Operation=1001, in_tag=5, out_ready=1, STAGES=2 -> out_valid for one cycle exactly 2 cycles after accept, Rd=32'hFF00_FF00, out_tag=5, out_illegal=0.
- Back-to-back ADD 32'hFFFF_FFFF+1, SUB 0-1, SRA 32'h8000_0000 by 4, SLT -1<1 with out_ready=1 -> Rd stream 0, 32'hFFFF_FFFF, 32'hF800_0000, 1, one per cycle in order.
- Hold out_ready=0 and issue 3 ops with STAGES=2 -> the first 2 are accepted, then in_ready=0 and Rd is stable. Raise out_ready -> the 3rd is accepted the same cycle the first drains; all 3 emerge in order with none lost.
- Two ops in flight plus a new input in the same cycle as flush=1 -> out_valid stays 0 for the next 3 cycles and busy=0. The next op after flush produces a correct result.
- Operation=1111, SrcA=7 -> Rd=0, out_illegal=1. The following XOR op has out_illegal=0.
- Assert reset while 2 ops are in flight and out_ready=0 -> next cycle out_valid=0, Rd=0, busy=0, in_ready=1.
